// File: rtl/data_mem_responder.sv
// Handshaked data-memory responder for the RV32I load/store port.
// One request at a time, a fixed number of wait states, then a single-cycle response.
module data_mem_responder #(
    parameter int ADDR_W      = 10,
    parameter int WAIT_STATES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [3:0] CNT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

    state_t      r_state;
    state_t      w_stateNext;
    logic [3:0]  r_cnt;
    logic [3:0]  w_cntNext;
    logic        w_accept;
    logic        w_commit;

    logic        r_write;
    logic [31:0] r_addr;
    logic [2:0]  r_funct3;
    logic [31:0] r_wdata;
    logic [31:0] r_rdata;
    logic        r_err;

    logic [31:0] r_mem [DEPTH];

    logic              w_write;
    logic [31:0]       w_addr;
    logic [2:0]        w_funct3;
    logic [31:0]       w_wdata;
    logic [ADDR_W-1:0] w_wordIdx;
    logic [1:0]        w_off;
    logic              w_outOfRange;
    logic              w_legal;
    logic              w_misaligned;
    logic              w_err;
    logic [3:0]        w_byteEn;
    logic [31:0]       w_laneData;
    logic [31:0]       w_word;
    logic [7:0]        w_byte;
    logic [15:0]       w_half;
    logic [31:0]       w_loadData;

    assign req_ready  = (r_state == ST_IDLE);
    assign resp_valid = (r_state == ST_RESP);
    assign resp_rdata = r_rdata;
    assign resp_err   = r_err;
    assign w_accept   = req_valid && req_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_stateNext;
            r_cnt   <= w_cntNext;
        end
    end

    // w_commit marks the edge that enters RESP: memory write and response capture.
    always_comb begin
        w_stateNext = r_state;
        w_cntNext   = r_cnt;
        w_commit    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (WAIT_STATES == 0) begin
                        w_stateNext = ST_RESP;
                        w_commit    = 1'b1;
                    end else begin
                        w_stateNext = ST_WAIT;
                        w_cntNext   = CNT_INIT;
                    end
                end
            end
            ST_WAIT: begin
                if (r_cnt == 4'd0) begin
                    w_stateNext = ST_RESP;
                    w_commit    = 1'b1;
                end else begin
                    w_cntNext = r_cnt - 4'd1;
                end
            end
            ST_RESP: begin
                w_stateNext = ST_IDLE;
            end
            default: begin
                w_stateNext = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_write  <= 1'b0;
            r_addr   <= 32'd0;
            r_funct3 <= 3'd0;
            r_wdata  <= 32'd0;
        end else if (w_accept) begin
            r_write  <= req_write;
            r_addr   <= req_addr;
            r_funct3 <= req_funct3;
            r_wdata  <= req_wdata;
        end
    end

    // With zero wait states the commit edge is the acceptance edge, so the live inputs are used.
    assign w_write  = (r_state == ST_IDLE) ? req_write  : r_write;
    assign w_addr   = (r_state == ST_IDLE) ? req_addr   : r_addr;
    assign w_funct3 = (r_state == ST_IDLE) ? req_funct3 : r_funct3;
    assign w_wdata  = (r_state == ST_IDLE) ? req_wdata  : r_wdata;

    assign w_wordIdx    = w_addr[ADDR_W+1:2];
    assign w_off        = w_addr[1:0];
    assign w_outOfRange = |w_addr[31:ADDR_W+2];
    assign w_err        = w_outOfRange || !w_legal || w_misaligned;

    always_comb begin
        w_legal      = 1'b0;
        w_misaligned = 1'b0;
        case (w_funct3)
            3'b000, 3'b001, 3'b010: w_legal = 1'b1;
            3'b100, 3'b101:         w_legal = !w_write;
            default:                w_legal = 1'b0;
        endcase
        case (w_funct3[1:0])
            2'b01:   w_misaligned = w_off[0];
            2'b10:   w_misaligned = |w_off;
            default: w_misaligned = 1'b0;
        endcase
    end

    always_comb begin
        w_byteEn   = 4'b1111;
        w_laneData = w_wdata;
        case (w_funct3[1:0])
            2'b00: begin
                w_byteEn   = 4'b0001 << w_off;
                w_laneData = {4{w_wdata[7:0]}};
            end
            2'b01: begin
                w_byteEn   = w_off[1] ? 4'b1100 : 4'b0011;
                w_laneData = {2{w_wdata[15:0]}};
            end
            default: begin
                w_byteEn   = 4'b1111;
                w_laneData = w_wdata;
            end
        endcase
    end

    assign w_word = r_mem[w_wordIdx];
    assign w_half = w_off[1] ? w_word[31:16] : w_word[15:0];

    always_comb begin
        w_byte = w_word[7:0];
        case (w_off)
            2'd0:    w_byte = w_word[7:0];
            2'd1:    w_byte = w_word[15:8];
            2'd2:    w_byte = w_word[23:16];
            default: w_byte = w_word[31:24];
        endcase
    end

    always_comb begin
        w_loadData = w_word;
        case (w_funct3)
            3'b000:  w_loadData = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_loadData = {{16{w_half[15]}}, w_half};
            3'b100:  w_loadData = {24'd0, w_byte};
            3'b101:  w_loadData = {16'd0, w_half};
            default: w_loadData = w_word;
        endcase
    end

    // Memory contents survive reset; only the commit edge of a clean store writes.
    always_ff @(posedge clk) begin
        if (!reset && w_commit && w_write && !w_err) begin
            for (int i = 0; i < 4; i++) begin
                if (w_byteEn[i]) begin
                    r_mem[w_wordIdx][i*8 +: 8] <= w_laneData[i*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rdata <= 32'd0;
            r_err   <= 1'b0;
        end else if (w_commit) begin
            r_err   <= w_err;
            r_rdata <= (w_err || w_write) ? 32'd0 : w_loadData;
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: one instance with two wait states, one with none.
// Shared request inputs; req_valid and the observed outputs are steered by 'sel'.
module tb_data_mem_responder;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        sel = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_write = 1'b0;
    logic [31:0] req_addr = 32'd0;
    logic [2:0]  req_funct3 = 3'd0;
    logic [31:0] req_wdata = 32'd0;

    logic        validA, readyA, respValidA, errA;
    logic        validB, readyB, respValidB, errB;
    logic [31:0] rdataA, rdataB;

    logic        w_ready, w_respValid, w_err;
    logic [31:0] w_rdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign validA      = req_valid && !sel;
    assign validB      = req_valid && sel;
    assign w_ready     = sel ? readyB : readyA;
    assign w_respValid = sel ? respValidB : respValidA;
    assign w_rdata     = sel ? rdataB : rdataA;
    assign w_err       = sel ? errB : errA;

    data_mem_responder #(.ADDR_W(10), .WAIT_STATES(2)) dutA (
        .clk(clk), .reset(reset),
        .req_valid(validA), .req_ready(readyA), .req_write(req_write),
        .req_addr(req_addr), .req_funct3(req_funct3), .req_wdata(req_wdata),
        .resp_valid(respValidA), .resp_rdata(rdataA), .resp_err(errA)
    );

    data_mem_responder #(.ADDR_W(10), .WAIT_STATES(0)) dutB (
        .clk(clk), .reset(reset),
        .req_valid(validB), .req_ready(readyB), .req_write(req_write),
        .req_addr(req_addr), .req_funct3(req_funct3), .req_wdata(req_wdata),
        .resp_valid(respValidB), .resp_rdata(rdataB), .resp_err(errB)
    );

    typedef struct {
        logic        sel;
        logic        wr;
        logic [31:0] addr;
        logic [2:0]  f3;
        logic [31:0] wdata;
        logic [31:0] expRd;
        logic        expErr;
        int          expLat;
    } vec_t;

    vec_t vecs[$];

    task automatic addVec(input logic s, input logic wr, input logic [31:0] a, input logic [2:0] f,
                          input logic [31:0] d, input logic [31:0] er, input logic ee);
        vec_t v;
        v.sel = s; v.wr = wr; v.addr = a; v.f3 = f; v.wdata = d;
        v.expRd = er; v.expErr = ee; v.expLat = s ? 1 : 3;
        vecs.push_back(v);
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Call at posedge+1. Latency counts edges from the acceptance edge to the one that raises resp_valid.
    task automatic applyStimulus(input logic wr, input logic [31:0] a, input logic [2:0] f,
                                 input logic [31:0] d, output logic [31:0] rd, output logic er,
                                 output int lat);
        bit acc = 1'b0;
        req_write = wr; req_addr = a; req_funct3 = f; req_wdata = d; req_valid = 1'b1;
        rd = 32'd0; er = 1'b0; lat = -1;
        for (int n = 0; n < 40 && !acc; n++) begin
            acc = w_ready;
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
        req_write = ~wr; req_addr = ~a; req_funct3 = ~f; req_wdata = ~d;
        if (acc) begin
            lat = 1;
            while (!w_respValid && lat < 40) begin
                @(posedge clk); #1;
                lat++;
            end
            rd = w_rdata;
            er = w_err;
        end
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat;
        int          accCyc[3];
        int          respCyc[3];
        int          k, nResp, nPulse;
        bit          acc;
        logic [31:0] b2bAddr[3];
        logic [31:0] b2bData[3];

        // WAIT_STATES=2 instance
        addVec(0, 1, 32'h10, 3'b010, 32'hDEADBEEF, 32'h0,        0);
        addVec(0, 0, 32'h10, 3'b010, 32'h0,        32'hDEADBEEF, 0);
        addVec(0, 1, 32'h20, 3'b010, 32'h0,        32'h0,        0);
        addVec(0, 1, 32'h21, 3'b000, 32'h00000080, 32'h0,        0);
        addVec(0, 0, 32'h20, 3'b010, 32'h0,        32'h00008000, 0);
        addVec(0, 0, 32'h21, 3'b000, 32'h0,        32'hFFFFFF80, 0);
        addVec(0, 0, 32'h21, 3'b100, 32'h0,        32'h00000080, 0);
        addVec(0, 0, 32'h23, 3'b001, 32'h0,        32'h0,        1);
        addVec(0, 0, 32'h1000, 3'b010, 32'h0,      32'h0,        1);
        addVec(0, 0, 32'h20, 3'b011, 32'h0,        32'h0,        1);
        addVec(0, 0, 32'h20, 3'b111, 32'h0,        32'h0,        1);
        addVec(0, 1, 32'h22, 3'b010, 32'hFFFFFFFF, 32'h0,        1);
        addVec(0, 1, 32'h1010, 3'b010, 32'hFFFFFFFF, 32'h0,      1);
        addVec(0, 1, 32'h21, 3'b001, 32'hFFFFFFFF, 32'h0,        1);
        addVec(0, 1, 32'h20, 3'b100, 32'hFFFFFFFF, 32'h0,        1);
        addVec(0, 0, 32'h20, 3'b010, 32'h0,        32'h00008000, 0);
        addVec(0, 0, 32'h10, 3'b010, 32'h0,        32'hDEADBEEF, 0);
        addVec(0, 1, 32'h22, 3'b001, 32'h1234FEDC, 32'h0,        0);
        addVec(0, 0, 32'h22, 3'b001, 32'h0,        32'hFFFFFEDC, 0);
        addVec(0, 0, 32'h22, 3'b101, 32'h0,        32'h0000FEDC, 0);
        addVec(0, 0, 32'h20, 3'b001, 32'h0,        32'hFFFF8000, 0);
        addVec(0, 0, 32'h20, 3'b101, 32'h0,        32'h00008000, 0);
        addVec(0, 0, 32'h22, 3'b000, 32'h0,        32'hFFFFFFDC, 0);
        addVec(0, 0, 32'h23, 3'b100, 32'h0,        32'h000000FE, 0);
        addVec(0, 1, 32'h23, 3'b000, 32'hFFFFFF5A, 32'h0,        0);
        addVec(0, 0, 32'h20, 3'b010, 32'h0,        32'h5ADC8000, 0);
        addVec(0, 0, 32'h20, 3'b000, 32'h0,        32'h0,        0);
        addVec(0, 1, 32'h20, 3'b001, 32'hFFFF7FFF, 32'h0,        0);
        addVec(0, 0, 32'h20, 3'b001, 32'h0,        32'h00007FFF, 0);
        // WAIT_STATES=0 instance
        addVec(1, 1, 32'h42, 3'b001, 32'h0000ABCD, 32'h0,        0);
        addVec(1, 0, 32'h42, 3'b101, 32'h0,        32'h0000ABCD, 0);
        addVec(1, 0, 32'h42, 3'b001, 32'h0,        32'hFFFFABCD, 0);
        addVec(1, 0, 32'h41, 3'b010, 32'h0,        32'h0,        1);
        addVec(1, 1, 32'h40, 3'b000, 32'h00000077, 32'h0,        0);
        addVec(1, 0, 32'h40, 3'b100, 32'h0,        32'h00000077, 0);
        addVec(1, 0, 32'h43, 3'b000, 32'h0,        32'hFFFFFFAB, 0);

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        checkOutput("reset readyA", {31'd0, readyA}, 32'd1);
        checkOutput("reset readyB", {31'd0, readyB}, 32'd1);
        checkOutput("reset resp_valid", {31'd0, respValidA}, 32'd0);
        checkOutput("reset resp_rdata", rdataA, 32'd0);
        checkOutput("reset resp_err", {31'd0, errA}, 32'd0);

        foreach (vecs[i]) begin
            sel = vecs[i].sel;
            applyStimulus(vecs[i].wr, vecs[i].addr, vecs[i].f3, vecs[i].wdata, rd, er, lat);
            checkOutput($sformatf("vec%0d rdata", i), rd, vecs[i].expRd);
            checkOutput($sformatf("vec%0d err", i), {31'd0, er}, {31'd0, vecs[i].expErr});
            checkOutput($sformatf("vec%0d latency", i), 32'(lat), 32'(vecs[i].expLat));
            @(posedge clk); #1;
        end

        // Back-to-back stores with req_valid held high throughout.
        sel = 1'b0;
        b2bAddr = '{32'h50, 32'h54, 32'h58};
        b2bData = '{32'hA1A1A1A1, 32'hB2B2B2B2, 32'hC3C3C3C3};
        accCyc = '{-100, -100, -100};
        respCyc = '{-100, -100, -100};
        k = 0; nResp = 0;
        req_write = 1'b1; req_funct3 = 3'b010;
        req_addr = b2bAddr[0]; req_wdata = b2bData[0]; req_valid = 1'b1;
        for (int cyc = 0; cyc < 30; cyc++) begin
            if (w_respValid) begin
                if (nResp < 3) respCyc[nResp] = cyc;
                nResp++;
            end
            acc = req_valid && w_ready;
            if (acc) accCyc[k] = cyc;
            @(posedge clk); #1;
            if (acc) begin
                k++;
                if (k < 3) begin
                    req_addr = b2bAddr[k]; req_wdata = b2bData[k];
                end else begin
                    req_valid = 1'b0;
                end
            end
        end
        req_valid = 1'b0;
        checkOutput("b2b accepts", 32'(k), 32'd3);
        checkOutput("b2b resp pulses", 32'(nResp), 32'd3);
        for (int i = 0; i < 3; i++)
            checkOutput($sformatf("b2b resp%0d latency", i), 32'(respCyc[i] - accCyc[i]), 32'd3);
        for (int i = 0; i < 2; i++)
            checkOutput($sformatf("b2b accept spacing%0d", i), 32'(accCyc[i+1] - accCyc[i]), 32'd4);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, b2bAddr[i], 3'b010, 32'd0, rd, er, lat);
            checkOutput($sformatf("b2b readback%0d", i), rd, b2bData[i]);
            @(posedge clk); #1;
        end

        // Reset while a store sits in WAIT: the store must vanish without a response.
        sel = 1'b0;
        applyStimulus(1'b1, 32'h30, 3'b010, 32'hCAFE0001, rd, er, lat);
        checkOutput("rst prestore err", {31'd0, er}, 32'd0);
        @(posedge clk); #1;
        req_write = 1'b1; req_addr = 32'h30; req_funct3 = 3'b010; req_wdata = 32'h12345678;
        req_valid = 1'b1;
        acc = w_ready;
        @(posedge clk); #1;
        req_valid = 1'b0;
        checkOutput("rst accepted", {31'd0, acc}, 32'd1);
        checkOutput("rst in wait ready", {31'd0, w_ready}, 32'd0);
        reset = 1'b1;
        @(posedge clk); #1;
        checkOutput("rst resp_valid during reset", {31'd0, w_respValid}, 32'd0);
        reset = 1'b0;
        checkOutput("rst ready after release", {31'd0, w_ready}, 32'd1);
        nPulse = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (w_respValid) nPulse++;
        end
        checkOutput("rst no response", 32'(nPulse), 32'd0);
        applyStimulus(1'b0, 32'h30, 3'b010, 32'd0, rd, er, lat);
        checkOutput("rst old value kept", rd, 32'hCAFE0001);
        @(posedge clk); #1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
